// File: rtl/display_scan_mux_if.sv
// Signal bundle between the clock/stopwatch datapath and the multiplexed
// 7-segment output stage. The master side supplies the encoded digits, the
// alarm level and the raw button. The slave side returns the segment bus, the
// digit enables and the view indicator.
interface display_scan_mux_if;
    logic [6:0] seg_hh1;
    logic [6:0] seg_hh2;
    logic [6:0] seg_mm1;
    logic [6:0] seg_mm2;
    logic [6:0] seg_ss1;
    logic [6:0] seg_ss2;
    logic [6:0] seg_sw_mm1;
    logic [6:0] seg_sw_mm2;
    logic [6:0] seg_sw_ss1;
    logic [6:0] seg_sw_ss2;
    logic       alarm_trigger;
    logic       mode_btn;
    logic [6:0] seg_out;
    logic [5:0] an;
    logic       mode_led;

    modport master (
        output seg_hh1, seg_hh2, seg_mm1, seg_mm2, seg_ss1, seg_ss2,
        output seg_sw_mm1, seg_sw_mm2, seg_sw_ss1, seg_sw_ss2,
        output alarm_trigger, mode_btn,
        input  seg_out, an, mode_led
    );

    modport slave (
        input  seg_hh1, seg_hh2, seg_mm1, seg_mm2, seg_ss1, seg_ss2,
        input  seg_sw_mm1, seg_sw_mm2, seg_sw_ss1, seg_sw_ss2,
        input  alarm_trigger, mode_btn,
        output seg_out, an, mode_led
    );
endinterface

// File: rtl/display_scan_mux.sv
// Time-multiplexes six clock digits or four stopwatch digits onto a shared
// 7-segment bus with active-low digit enables. It debounces the view-select
// button and blanks the whole display in alternating windows while the alarm
// is active.
module display_scan_mux #(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned BLINK_DIV       = 64
) (
    input logic                clk,
    input logic                rst,
    display_scan_mux_if.slave  bus
);

    localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned BLINK_W = $clog2(BLINK_DIV);

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        HELD,
        RELEASE
    } db_state_t;

    logic [SCAN_W-1:0]  scan_cnt_q;
    logic [2:0]         d_q;
    logic               sync1_q;
    logic               sync2_q;
    db_state_t          state_q;
    logic [DB_W-1:0]    db_cnt_q;
    logic               mode_q;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_phase_q;
    logic [6:0]         seg_q;
    logic [5:0]         an_q;
    logic [6:0]         seg_d;
    logic [5:0]         an_d;
    logic               mode_toggle;

    // Accepting a press happens on the same edge that flips the view, so the
    // scan restart below can key off it.
    assign mode_toggle = (state_q == PRESS) && sync2_q && (db_cnt_q == DB_LAST);

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.mode_btn;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM. It issues one view toggle per accepted press and needs a
    // stable release before it arms again.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            db_cnt_q <= '0;
            mode_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sync2_q) begin
                        state_q  <= PRESS;
                        db_cnt_q <= '0;
                    end
                end
                PRESS: begin
                    if (!sync2_q) begin
                        state_q <= IDLE;
                    end else if (db_cnt_q == DB_LAST) begin
                        mode_q  <= ~mode_q;
                        state_q <= HELD;
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!sync2_q) begin
                        state_q  <= RELEASE;
                        db_cnt_q <= '0;
                    end
                end
                RELEASE: begin
                    if (sync2_q) begin
                        state_q <= HELD;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Scan divider and digit index. A view toggle restarts the frame at
    // position 0 and takes priority over a wrap on the same edge.
    always_ff @(posedge clk) begin
        if (!rst || mode_toggle) begin
            scan_cnt_q <= '0;
            d_q        <= '0;
        end else if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_q <= '0;
            d_q        <= (d_q == 3'd5) ? 3'd0 : d_q + 3'd1;
        end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
        end
    end

    // Alarm blink divider. It is held in the visible phase while the alarm
    // is off.
    always_ff @(posedge clk) begin
        if (!rst || !bus.alarm_trigger) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    // Select the segments and enable for the current slot. The display is
    // blank during the dark blink phase and in the unused stopwatch slots.
    always_comb begin
        seg_d = '0;
        an_d  = '1;
        if (!blink_phase_q) begin
            if (!mode_q) begin
                case (d_q)
                    3'd0:    begin seg_d = bus.seg_hh1; an_d = 6'b111110; end
                    3'd1:    begin seg_d = bus.seg_hh2; an_d = 6'b111101; end
                    3'd2:    begin seg_d = bus.seg_mm1; an_d = 6'b111011; end
                    3'd3:    begin seg_d = bus.seg_mm2; an_d = 6'b110111; end
                    3'd4:    begin seg_d = bus.seg_ss1; an_d = 6'b101111; end
                    3'd5:    begin seg_d = bus.seg_ss2; an_d = 6'b011111; end
                    default: begin seg_d = '0;          an_d = '1;        end
                endcase
            end else begin
                case (d_q)
                    3'd2:    begin seg_d = bus.seg_sw_mm1; an_d = 6'b111011; end
                    3'd3:    begin seg_d = bus.seg_sw_mm2; an_d = 6'b110111; end
                    3'd4:    begin seg_d = bus.seg_sw_ss1; an_d = 6'b101111; end
                    3'd5:    begin seg_d = bus.seg_sw_ss2; an_d = 6'b011111; end
                    default: begin seg_d = '0;             an_d = '1;        end
                endcase
            end
        end
    end

    // Output registers that drive the display pins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            seg_q <= '0;
            an_q  <= '1;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign bus.seg_out  = seg_q;
    assign bus.an       = an_q;
    assign bus.mode_led = mode_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux. Before each clock edge the expected
// display after that edge is pushed, using the spec's timing relations. After
// the edge the entry is popped and compared with the DUT outputs.
module tb_display_scan_mux;

    localparam int SD = 4;
    localparam int DB = 4;
    localparam int BD = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn = 1'b0;
    logic alarm = 1'b0;
    logic [6:0] clk_dig [6];
    logic [6:0] sw_dig [4];

    always #5 clk = ~clk;

    display_scan_mux_if bus_if ();

    assign bus_if.seg_hh1       = clk_dig[0];
    assign bus_if.seg_hh2       = clk_dig[1];
    assign bus_if.seg_mm1       = clk_dig[2];
    assign bus_if.seg_mm2       = clk_dig[3];
    assign bus_if.seg_ss1       = clk_dig[4];
    assign bus_if.seg_ss2       = clk_dig[5];
    assign bus_if.seg_sw_mm1    = sw_dig[0];
    assign bus_if.seg_sw_mm2    = sw_dig[1];
    assign bus_if.seg_sw_ss1    = sw_dig[2];
    assign bus_if.seg_sw_ss2    = sw_dig[3];
    assign bus_if.alarm_trigger = alarm;
    assign bus_if.mode_btn      = btn;

    display_scan_mux #(
        .SCAN_DIV(SD),
        .DEBOUNCE_CYCLES(DB),
        .BLINK_DIV(BD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if.slave)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic [5:0] an;
        logic       mode;
    } exp_t;

    exp_t sb_q[$];

    int   total = 0;
    int   bad = 0;
    int   ecnt = 0;         // edges seen so far
    int   toggle_edge = -1; // edge number at which mode_led must flip
    int   m_tick = 0;       // edges since the scan frame last restarted
    logic m_mode = 1'b0;
    int   m_acnt = 0;       // edges with alarm sampled high
    logic m_phase = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, ecnt);
        end
    endtask

    task automatic step();
        exp_t e;
        exp_t o;
        int pos;
        bit tog;
        logic [5:0] oh;
        pos = (m_tick / SD) % 6;
        oh  = 6'b000001 << pos;
        tog = rst && (ecnt + 1 == toggle_edge);
        e.seg  = '0;
        e.an   = 6'h3F;
        e.mode = 1'b0;
        if (rst) begin
            if (!m_phase) begin
                if (!m_mode) begin
                    e.seg = clk_dig[pos];
                    e.an  = ~oh;
                end else if (pos >= 2) begin
                    e.seg = sw_dig[pos - 2];
                    e.an  = ~oh;
                end
            end
            e.mode = m_mode ^ tog;
        end
        sb_q.push_back(e);
        @(posedge clk);
        ecnt++;
        if (!rst) begin
            m_tick = 0;
            m_mode = 1'b0;
            m_acnt = 0;
            m_phase = 1'b0;
            toggle_edge = -1;
        end else begin
            if (tog) begin
                m_mode = ~m_mode;
                m_tick = 0;
            end else begin
                m_tick++;
            end
            if (alarm) begin
                m_acnt++;
                m_phase = ((m_acnt / BD) % 2) == 1;
            end else begin
                m_acnt = 0;
                m_phase = 1'b0;
            end
        end
        #1;
        o = sb_q.pop_front();
        check("seg_out", 32'(bus_if.seg_out), 32'(o.seg));
        check("an", 32'(bus_if.an), 32'(o.an));
        check("mode_led", 32'(bus_if.mode_led), 32'(o.mode));
    endtask

    initial begin
        for (int i = 0; i < 6; i++) clk_dig[i] = 7'(i + 1);
        for (int i = 0; i < 4; i++) sw_dig[i] = 7'(8'h11 + i);

        // reset, then two full clock-view frames
        repeat (3) step();
        rst = 1'b1;
        repeat (48) step();

        // live update of mm2 while position 3 is lit
        for (int i = 0; i < 30 && !(((m_tick / SD) % 6) == 3 && (m_tick % SD) == 1); i++) step();
        clk_dig[3] = 7'h5A;
        repeat (2) step();

        // short press is rejected
        btn = 1'b1;
        repeat (3) step();
        btn = 1'b0;
        repeat (10) step();

        // held press toggles once; release bounce adds nothing
        btn = 1'b1;
        toggle_edge = ecnt + DB + 3;
        repeat (20) step();
        btn = 1'b0;
        repeat (2) step();
        btn = 1'b1;
        repeat (8) step();
        btn = 1'b0;
        repeat (12) step();
        repeat (24) step();

        // alarm blink, drop, then re-assert from a fresh count
        alarm = 1'b1;
        repeat (40) step();
        alarm = 1'b0;
        repeat (4) step();
        alarm = 1'b1;
        repeat (12) step();
        alarm = 1'b0;
        repeat (4) step();

        // reset in the dark blink phase
        alarm = 1'b1;
        repeat (10) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        repeat (12) step();
        alarm = 1'b0;
        repeat (4) step();

        // reset during a press discards it
        btn = 1'b1;
        repeat (4) step();
        rst = 1'b0;
        btn = 1'b0;
        step();
        rst = 1'b1;
        repeat (16) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scan_mux.md
# display_scan_mux

Output stage fed by `DigitalClockWithStopwatch`. It takes the six clock digits, the four stopwatch digits and `alarm_trigger`, already 7-segment encoded, and time-multiplexes them onto one shared segment bus with per-digit enables. It also owns the debounced clock/stopwatch view-select button and blinks the whole display while the alarm is active. Outputs drive the board's 6-digit multiplexed 7-segment display directly.

## Interface
- `SCAN_DIV`, default 1000: clk cycles each digit stays lit (≥2).
- `DEBOUNCE_CYCLES`, default 16: stable-level cycles required to accept a button press or release (≥2).
- `BLINK_DIV`, default 64: clk cycles per blink half-period while the alarm is active (≥2).
- `clk`  input  1  system clock.
- `rst`  input  1  synchronous, active-low reset (0 = reset, sampled on rising `clk`).
- `seg_hh1`, `seg_hh2`, `seg_mm1`, `seg_mm2`, `seg_ss1`, `seg_ss2`  input  7 each  clock digits, active-high segments.
- `seg_sw_mm1`, `seg_sw_mm2`, `seg_sw_ss1`, `seg_sw_ss2`  input  7 each  stopwatch digits, active-high segments.
- `alarm_trigger`  input  1  alarm active (level).
- `mode_btn`  input  1  raw asynchronous view-select button, active-high.
- `seg_out`  output  7  segment bus, active-high.
- `an`  output  6  digit enables, active-low; `an[i]` lights position i (0 = leftmost).
- `mode_led`  output  1  0 = clock view, 1 = stopwatch view.

## Operation
- **Scan**
  - `scan_cnt` counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it wraps to 0 and digit index `d` advances 0→1→…→5→0.
- **Clock view** (`mode_led`=0): positions 0..5 show hh1, hh2, mm1, mm2, ss1, ss2.
- **Stopwatch view** (`mode_led`=1)
  - Positions 2..5 show sw_mm1, sw_mm2, sw_ss1, sw_ss2.
  - Positions 0..1 are blank: `an`=6'b111111 and `seg_out`=0 during those slots.
- **Output registers**
  - `seg_out` and `an` are registered from `d`, the mode, the blink phase and the current input digits.
  - Only one `an` bit is ever low.
- **Button path**
  - Two-flop synchronizer feeds a debounce FSM with a counter `db_cnt`.
  - IDLE: sync=1 → PRESS, `db_cnt`=0.
  - PRESS: sync=0 → IDLE. Otherwise `db_cnt`++. When `db_cnt`==DEBOUNCE_CYCLES-1: toggle mode, go to HELD.
  - HELD: sync=0 → RELEASE, `db_cnt`=0.
  - RELEASE: sync=1 → HELD. Otherwise `db_cnt`++. When `db_cnt`==DEBOUNCE_CYCLES-1: go to IDLE.
  - Exactly one toggle per press, however long the button is held.
- **Mode toggle side effect**: `d` and `scan_cnt` are forced to 0 on the toggle edge. This overrides a simultaneous scan wrap.
- **Alarm blink**
  - While `alarm_trigger`=1, `blink_cnt` counts 0..BLINK_DIV-1. On wrap, `blink_phase` toggles (0 = visible, 1 = dark).
  - While `alarm_trigger`=0, `blink_cnt`=0 and `blink_phase`=0.
  - `blink_phase`=1 forces `an`=6'b111111 and `seg_out`=0 in both views. Scanning continues underneath.

## Timing
- **Reset** (rst=0 at an edge)
  - Outputs: `seg_out`=0, `an`=6'b111111, `mode_led`=0.
  - Internal state: `d`=0, `scan_cnt`=0, FSM=IDLE, `db_cnt`=0, `blink_cnt`=0, `blink_phase`=0, synchronizer flops=0.
  - Reset mid-press discards the press. Reset mid-blink returns to the visible phase.
- **Display latency**: `seg_out`/`an` reflect the state (`d`, mode, blink phase) one edge late.
  - First edge after rst returns to 1: `an`=6'b111110, `seg_out`=`seg_hh1`.
  - An input digit change appears on `seg_out` one edge later, if that digit is selected.
- **Scan period**: each digit is lit for exactly SCAN_DIV cycles. A full frame is 6·SCAN_DIV cycles.
- **Button latency**: `mode_btn` first sampled high at edge k and held → `mode_led` toggles at edge k+DEBOUNCE_CYCLES+2. The new view is on `an`/`seg_out` at edge k+DEBOUNCE_CYCLES+3, starting at position 0.
- **Glitch rejection**: a high or low pulse shorter than DEBOUNCE_CYCLES synchronized cycles causes no toggle.
- **Blink latency**
  - `alarm_trigger` rising at edge j → `blink_phase`=1 at edge j+BLINK_DIV, displayed at j+BLINK_DIV+1.
  - After that, `blink_phase` toggles every BLINK_DIV cycles.
  - `alarm_trigger` falling → display visible again within 2 edges.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE_CYCLES=4, BLINK_DIV=8.
- **Reset/scan**: rst=0 for 3 cycles, then rst=1; `seg_hh1`..`seg_ss2`=7'h01..7'h06 → `an` cycles 111110, 111101, 111011, 110111, 101111, 011111 with `seg_out` 7'h01..7'h06, each held exactly 4 cycles, first at the edge after rst=1.
- **View toggle**: hold `mode_btn`=1 for 20 cycles → `mode_led`=1 exactly 6 edges after first sample. Only positions 2..5 are lit, showing the four stopwatch digits. No second toggle while held.
- **Debounce**: pulse `mode_btn`=1 for 3 cycles, then 0 → `mode_led` stays 0. A release bounce of 2 low cycles while held → no extra toggle.
- **Alarm blink**: `alarm_trigger`=1 for 40 cycles → display dark (`an`=111111, `seg_out`=0) for 8-cycle windows alternating with lit windows. Drop `alarm_trigger` → lit within 2 cycles; `blink_cnt` restarts from 0 on the next assert.
- **Reset mid-operation**: pull rst=0 during PRESS and during a dark blink phase → all outputs at reset values on that edge. `mode_led` is unchanged from 0 after release.
- **Live digit update**: change `seg_mm2` while position 3 is active → `seg_out` shows the new value on the next edge with no change to `an`.
